// File: rtl/sat_clause_checker.sv
// rtl/sat_clause_checker.sv - programmable 3-CNF formula evaluator
//
// Holds up to MAX_CLAUSES three-literal clauses loaded through a write port
// and evaluates them one clause per cycle against a latched candidate
// assignment. A registered done pulse carries the sat verdict and the index
// of the first failing clause.
//
// Optional build macro: SAT_EARLY_EXIT_EN -- leave EVAL on the first false
// clause instead of always walking all active clauses. Results are identical
// either way; only latency differs.
//
// Ports:
//   clk          clock
//   reset        asynchronous active-high reset
//   cfg_we       clause memory write enable (honoured only in IDLE)
//   cfg_addr     clause slot to write
//   cfg_data     clause; literal k at [k*LW +: LW], bit VW = negate,
//                bits [VW-1:0] = variable index (index >= NUM_VARS is padding)
//   num_clauses  active clause count, sampled on start (clipped to MAX_CLAUSES)
//   start        begin evaluation, accepted only in IDLE
//   assign_in    candidate assignment, sampled on start; bit i = x_i
//   busy         high in EVAL and DONE
//   done         one-cycle result-valid pulse
//   sat          formula satisfied; held until next result
//   fail_idx     first unsatisfied clause index; 0 when sat

module sat_clause_checker #(
  parameter int NUM_VARS    = 3,
  parameter int MAX_CLAUSES = 8,
  localparam int VW  = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1,
  localparam int CW  = (MAX_CLAUSES > 1) ? $clog2(MAX_CLAUSES) : 1,
  localparam int LW  = VW + 1,
  localparam int CLW = 3 * LW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [CW-1:0]       cfg_addr,
  input  logic [CLW-1:0]      cfg_data,
  input  logic [CW:0]         num_clauses,
  input  logic                start,
  input  logic [NUM_VARS-1:0] assign_in,
  output logic                busy,
  output logic                done,
  output logic                sat,
  output logic [CW-1:0]       fail_idx
);

  localparam int AW = 1 << VW;
  localparam logic [CW:0] MAX_CNT = (CW+1)'(MAX_CLAUSES);
  localparam logic [VW:0] NV      = (VW+1)'(NUM_VARS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_VARS-1:0] assign_q, assign_d;
  logic [CW:0]         cnt_q, cnt_d;
  logic [CW-1:0]       idx_q, idx_d;
  logic                fail_q, fail_d;
  logic [CW-1:0]       frec_q, frec_d;
  logic                sat_q, sat_d;
  logic [CW-1:0]       fail_idx_q, fail_idx_d;

  // Clause storage: deliberately not reset so a reset mid-run keeps the formula.
  logic [CLW-1:0]      mem_q [MAX_CLAUSES];

  logic [CLW-1:0]      clause;
  logic [LW-1:0]       lit;
  logic [AW-1:0]       assign_ext;
  logic                clause_ok;
  logic                ok_eff;
  logic                last;
  logic [CW:0]         cnt_in;
  logic                fail_now;
  logic [CW-1:0]       rec_now;
  logic                exit_eval;

  assign clause     = mem_q[idx_q];
  assign assign_ext = AW'(assign_q);
  assign cnt_in     = (num_clauses > MAX_CNT) ? MAX_CNT : num_clauses;

  // OR of three literals; a padding index contributes false whatever its negate bit.
  always_comb begin
    clause_ok = 1'b0;
    lit       = '0;
    for (int k = 0; k < 3; k++) begin
      lit = clause[k*LW +: LW];
      if ({1'b0, lit[VW-1:0]} < NV) begin
        clause_ok = clause_ok | (assign_ext[lit[VW-1:0]] ^ lit[VW]);
      end
    end
  end

  // cnt=0 still passes through EVAL for one cycle so latency matches cnt=1;
  // that pass is treated as a satisfied final clause.
  assign ok_eff = clause_ok || (cnt_q == '0);
  assign last   = (cnt_q == '0) || ({1'b0, idx_q} == (cnt_q - (CW+1)'(1)));

  always_comb begin
    state_d    = state_q;
    assign_d   = assign_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    fail_d     = fail_q;
    frec_d     = frec_q;
    sat_d      = sat_q;
    fail_idx_d = fail_idx_q;
    fail_now   = 1'b0;
    rec_now    = '0;
    exit_eval  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          assign_d = assign_in;
          cnt_d    = cnt_in;
          idx_d    = '0;
          fail_d   = 1'b0;
          frec_d   = '0;
          state_d  = ST_EVAL;
        end
      end
      ST_EVAL: begin
        // Only the first failure is recorded; later false clauses keep it.
        fail_now  = fail_q | ~ok_eff;
        rec_now   = fail_q ? frec_q : idx_q;
        fail_d    = fail_now;
        frec_d    = rec_now;
        exit_eval = last;
`ifdef SAT_EARLY_EXIT_EN
        if (!ok_eff) begin
          exit_eval = 1'b1;
        end
`endif
        if (exit_eval) begin
          state_d    = ST_DONE;
          sat_d      = ~fail_now;
          fail_idx_d = fail_now ? rec_now : '0;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      assign_q   <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      fail_q     <= 1'b0;
      frec_q     <= '0;
      sat_q      <= 1'b0;
      fail_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      assign_q   <= assign_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      fail_q     <= fail_d;
      frec_q     <= frec_d;
      sat_q      <= sat_d;
      fail_idx_q <= fail_idx_d;
    end
  end

  // Writes land only in IDLE; a write in the start cycle is visible because the
  // first clause is read on the following cycle.
  always_ff @(posedge clk) begin
    if (cfg_we && (state_q == ST_IDLE) && ({1'b0, cfg_addr} < MAX_CNT)) begin
      mem_q[cfg_addr] <= cfg_data;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign sat      = sat_q;
  assign fail_idx = fail_idx_q;

endmodule

// File: tb/tb_sat_clause_checker.sv
// tb/tb_sat_clause_checker.sv - directed self-checking bench for sat_clause_checker
//
// Drives and samples on the falling clock edge. Latency is counted in falling
// edges after the start cycle, so a single-clause run reports 2.

module tb_sat_clause_checker;

`ifdef SAT_EARLY_EXIT_EN
  localparam int EARLY_LAT = 2;
`else
  localparam int EARLY_LAT = 3;
`endif

  logic       clk;
  logic       reset;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [8:0] cfg_data;
  logic [3:0] num_clauses;
  logic       start;
  logic [2:0] assign_in;
  logic       busy;
  logic       done;
  logic       sat;
  logic [2:0] fail_idx;

  int n_checks = 0;
  int n_fail   = 0;

  sat_clause_checker #(.NUM_VARS(3), .MAX_CLAUSES(8)) dut (
    .clk(clk),
    .reset(reset),
    .cfg_we(cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .num_clauses(num_clauses),
    .start(start),
    .assign_in(assign_in),
    .busy(busy),
    .done(done),
    .sat(sat),
    .fail_idx(fail_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic write_clause(input logic [2:0] a, input logic [8:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // wmode: 0 none, 1 write in the start cycle, 2 write in the first busy cycle
  task automatic run(input logic [2:0] a, input logic [3:0] nc, input int wmode,
                     input logic [2:0] wa, input logic [8:0] wd,
                     output int lat, output logic s, output logic [2:0] fi,
                     output logic b1, output logic dn_after);
    @(negedge clk);
    assign_in = a; num_clauses = nc; start = 1'b1;
    if (wmode == 1) begin cfg_we = 1'b1; cfg_addr = wa; cfg_data = wd; end
    @(negedge clk);
    start = 1'b0; cfg_we = 1'b0;
    assign_in = ~a; num_clauses = 4'd0;
    b1 = busy;
    if (wmode == 2) begin cfg_we = 1'b1; cfg_addr = wa; cfg_data = wd; end
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      cfg_we = 1'b0;
      lat++;
    end
    s  = sat;
    fi = fail_idx;
    @(negedge clk);
    cfg_we = 1'b0;
    dn_after = done;
  endtask

  task automatic test_reset;
    #12;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b want 0", sat); end
    n_checks++; if (fail_idx !== 3'd0) begin n_fail++; $display("FAIL reset_fail_idx: got %0d want 0", fail_idx); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_clause;
    int lat; logic s; logic [2:0] fi; logic b1; logic da;
    write_clause(3'd0, 9'b000_000_000);
    run(3'b001, 4'd1, 0, 3'd0, 9'd0, lat, s, fi, b1, da);
    n_checks++; if (b1 !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", b1); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL single_sat_lat: got %0d want 2", lat); end
    n_checks++; if (s !== 1'b1) begin n_fail++; $display("FAIL single_sat: got %b want 1", s); end
    n_checks++; if (fi !== 3'd0) begin n_fail++; $display("FAIL single_sat_idx: got %0d want 0", fi); end
    n_checks++; if (da !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: got %b want 0", da); end
    run(3'b000, 4'd1, 0, 3'd0, 9'd0, lat, s, fi, b1, da);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL single_unsat_lat: got %0d want 2", lat); end
    n_checks++; if (s !== 1'b0) begin n_fail++; $display("FAIL single_unsat: got %b want 0", s); end
    n_checks++; if (fi !== 3'd0) begin n_fail++; $display("FAIL single_unsat_idx: got %0d want 0", fi); end
  endtask

  task automatic test_two_clauses;
    int lat; logic s; logic [2:0] fi; logic b1; logic da;
    write_clause(3'd0, 9'b010_001_000);
    write_clause(3'd1, 9'b110_101_100);
    run(3'b111, 4'd2, 0, 3'd0, 9'd0, lat, s, fi, b1, da);
    n_checks++; if (s !== 1'b0) begin n_fail++; $display("FAIL two_111_sat: got %b want 0", s); end
    n_checks++; if (fi !== 3'd1) begin n_fail++; $display("FAIL two_111_idx: got %0d want 1", fi); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL two_111_lat: got %0d want 3", lat); end
    run(3'b011, 4'd2, 0, 3'd0, 9'd0, lat, s, fi, b1, da);
    n_checks++; if (s !== 1'b1) begin n_fail++; $display("FAIL two_011_sat: got %b want 1", s); end
    n_checks++; if (fi !== 3'd0) begin n_fail++; $display("FAIL two_011_idx: got %0d want 0", fi); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL two_011_lat: got %0d want 3", lat); end
    run(3'b000, 4'd2, 0, 3'd0, 9'd0, lat, s, fi, b1, da);
    n_checks++; if (s !== 1'b0) begin n_fail++; $display("FAIL two_000_sat: got %b want 0", s); end
    n_checks++; if (fi !== 3'd0) begin n_fail++; $display("FAIL two_000_idx: got %0d want 0", fi); end
    n_checks++; if (lat !== EARLY_LAT) begin n_fail++; $display("FAIL two_000_lat: got %0d want %0d", lat, EARLY_LAT); end
  endtask

  task automatic test_write_with_start;
    int lat; logic s; logic [2:0] fi; logic b1; logic da;
    write_clause(3'd0, 9'b000_000_000);
    write_clause(3'd1, 9'b001_001_001);
    run(3'b001, 4'd2, 1, 3'd1, 9'b000_000_000, lat, s, fi, b1, da);
    n_checks++; if (s !== 1'b1) begin n_fail++; $display("FAIL wr_start_sat: got %b want 1", s); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL wr_start_lat: got %0d want 3", lat); end
  endtask

  task automatic test_boundary_counts;
    int lat; logic s; logic [2:0] fi; logic b1; logic da;
    write_clause(3'd0, 9'b010_001_000);
    write_clause(3'd1, 9'b110_101_100);
    for (int i = 2; i < 7; i++) write_clause(3'(i), 9'b000_000_000);
    write_clause(3'd7, 9'b001_001_001);
    run(3'b001, 4'd12, 0, 3'd0, 9'd0, lat, s, fi, b1, da);
    n_checks++; if (s !== 1'b0) begin n_fail++; $display("FAIL clip_unsat: got %b want 0", s); end
    n_checks++; if (fi !== 3'd7) begin n_fail++; $display("FAIL clip_unsat_idx: got %0d want 7", fi); end
    n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL clip_unsat_lat: got %0d want 9", lat); end
    run(3'b001, 4'd0, 0, 3'd0, 9'd0, lat, s, fi, b1, da);
    n_checks++; if (s !== 1'b1) begin n_fail++; $display("FAIL zero_sat: got %b want 1", s); end
    n_checks++; if (fi !== 3'd0) begin n_fail++; $display("FAIL zero_idx: got %0d want 0", fi); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL zero_lat: got %0d want 2", lat); end
    run(3'b001, 4'd7, 0, 3'd0, 9'd0, lat, s, fi, b1, da);
    n_checks++; if (s !== 1'b1) begin n_fail++; $display("FAIL cnt7_sat: got %b want 1", s); end
    n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL cnt7_lat: got %0d want 8", lat); end
    run(3'b011, 4'd12, 0, 3'd0, 9'd0, lat, s, fi, b1, da);
    n_checks++; if (s !== 1'b1) begin n_fail++; $display("FAIL clip_sat: got %b want 1", s); end
    n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL clip_sat_lat: got %0d want 9", lat); end
  endtask

  task automatic test_reset_mid_eval;
    int lat; logic s; logic [2:0] fi; logic b1; logic da;
    int seen;
    @(negedge clk);
    assign_in = 3'b001; num_clauses = 4'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
    n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL mid_reset_sat: got %b want 0", sat); end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL mid_reset_no_done: got %0d pulses want 0", seen); end
    run(3'b001, 4'd8, 2, 3'd7, 9'b000_000_000, lat, s, fi, b1, da);
    n_checks++; if (s !== 1'b0) begin n_fail++; $display("FAIL retained_sat: got %b want 0", s); end
    n_checks++; if (fi !== 3'd7) begin n_fail++; $display("FAIL retained_idx: got %0d want 7", fi); end
    n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL retained_lat: got %0d want 9", lat); end
    run(3'b001, 4'd8, 0, 3'd0, 9'd0, lat, s, fi, b1, da);
    n_checks++; if (fi !== 3'd7) begin n_fail++; $display("FAIL busy_write_dropped: got %0d want 7", fi); end
  endtask

  task automatic test_padding;
    int lat; logic s; logic [2:0] fi; logic b1; logic da;
    write_clause(3'd0, 9'b011_011_000);
    run(3'b110, 4'd1, 0, 3'd0, 9'd0, lat, s, fi, b1, da);
    n_checks++; if (s !== 1'b0) begin n_fail++; $display("FAIL pad_110: got %b want 0", s); end
    run(3'b001, 4'd1, 0, 3'd0, 9'd0, lat, s, fi, b1, da);
    n_checks++; if (s !== 1'b1) begin n_fail++; $display("FAIL pad_001: got %b want 1", s); end
    write_clause(3'd0, 9'b111_111_000);
    run(3'b110, 4'd1, 0, 3'd0, 9'd0, lat, s, fi, b1, da);
    n_checks++; if (s !== 1'b0) begin n_fail++; $display("FAIL pad_neg_110: got %b want 0", s); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    assign_in = 3'b001; num_clauses = 4'd1; start = 1'b1;
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_n1_done: got %b want 0", done); end
    @(negedge clk);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_n2_done: got %b want 1", done); end
    n_checks++; if (sat !== 1'b1) begin n_fail++; $display("FAIL b2b_sat: got %b want 1", sat); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap: got %b want 0", busy); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_busy: got %b want 1", busy); end
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done: got %b want 1", done); end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    num_clauses = '0; start = 1'b0; assign_in = '0;
    test_reset;
    test_single_clause;
    test_two_clauses;
    test_write_with_start;
    test_boundary_counts;
    test_reset_mid_eval;
    test_padding;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
